// File: rtl/mem_bus_arbiter_if.sv
// Bundles the two requester ports and the shared memory port of mem_bus_arbiter.
// slave: the arbiter's view; master: the requesters and memory side driving it.
interface mem_bus_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_ack;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_ack;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_mw;
    logic                  mem_mr;
    logic [1:0]            gnt;
    logic                  busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output mem_addr, mem_wdata, mem_mw, mem_mr, gnt, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  mem_addr, mem_wdata, mem_mw, mem_mr, gnt, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port req/ack arbiter sharing one RAM/peripheral port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to port 0.
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The counter holds the number of read cycles still to go after the current one.
    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  mw_q, mw_d;
    logic                  mr_q, mr_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  pick;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        if (bus.m0_req && bus.m1_req) begin
            pick = ~last_q;
        end else begin
            pick = ~bus.m0_req;
        end
    end
`else
    assign pick = ~bus.m0_req;
`endif

    always_comb begin
        // NOTE: every next value takes a default before the case, so no branch can infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt_d    = gnt_q;
        mw_d     = 1'b0;
        mr_d     = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    owner_d = pick;
                    we_d    = pick ? bus.m1_we    : bus.m0_we;
                    addr_d  = pick ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    mw_d    = we_d;
                    mr_d    = ~we_d;
                    cnt_d   = we_d ? 4'd0 : LAT_LOAD;
                    state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = pick;
`endif
                end
            end

            ACCESS: begin
                if (we_q || cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_d = bus.mem_rdata;
                        end else begin
                            rdata0_d = bus.mem_rdata;
                        end
                    end
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    mr_d  = 1'b1;
                end
            end

            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            // NOTE: the rdata holding registers are reset too, since they are visible on the ports.
            rdata0_q <= '0;
            rdata1_q <= '0;
            gnt_q    <= 2'b00;
            mw_q     <= 1'b0;
            mr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            gnt_q    <= gnt_d;
            mw_q     <= mw_d;
            mr_q     <= mr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mw    = mw_q;
    assign bus.mem_mr    = mr_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m0_ack    = ack0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m1_ack    = ack1_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-timeline model (honours ARB_ROUND_ROBIN_EN).
module tb_mem_bus_arbiter;
    localparam int DW     = 8;
    localparam int AW     = 8;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   cmp_en   = 1'b0;

    mem_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_bus_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'(a) ^ 8'h5A;
    endfunction

    // Memory behind the arbiter: reset-independent, follows the DUT's strobes.
    logic [DW-1:0] ram_data [256];
    bit            ram_wr   [256];
    assign bus.mem_rdata = ram_wr[bus.mem_addr] ? ram_data[bus.mem_addr] : init_val(bus.mem_addr);

    always @(posedge clk) begin
        if (bus.mem_mw) begin
            ram_data[bus.mem_addr] <= bus.mem_wdata;
            ram_wr[bus.mem_addr]   <= 1'b1;
        end
    end

    // Reference model: one transaction on a timeline. m_p counts edges since the sampling edge;
    // strobes cover p = 1..D, ack is p = D+1, and the bus is idle again from p = D+2.
    bit            m_active;
    int            m_p;
    logic          m_port, m_we, m_last, m_win;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata0, m_rdata1;
    logic [DW-1:0] exp_mem [256];
    bit            exp_wr  [256];

    function automatic int dur();
        return m_we ? 1 : RD_LAT;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        return exp_wr[a] ? exp_mem[a] : init_val(a);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_p      = 0;
            m_port   = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_rdata0 = '0;
            m_rdata1 = '0;
            m_last   = 1'b1;
        end else if (m_active) begin
            m_p++;
            if (m_p == dur() + 1) begin
                if (m_we) begin
                    exp_mem[m_addr] = m_wdata;
                    exp_wr[m_addr]  = 1'b1;
                end else if (m_port) begin
                    m_rdata1 = exp_read(m_addr);
                end else begin
                    m_rdata0 = exp_read(m_addr);
                end
            end else if (m_p == dur() + 2) begin
                m_active = 1'b0;
            end
        end else if (bus.m0_req || bus.m1_req) begin
            m_win = bus.m0_req ? 1'b0 : 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.m0_req && bus.m1_req) m_win = ~m_last;
`endif
            m_last   = m_win;
            m_port   = m_win;
            m_we     = m_win ? bus.m1_we    : bus.m0_we;
            m_addr   = m_win ? bus.m1_addr  : bus.m0_addr;
            m_wdata  = m_win ? bus.m1_wdata : bus.m0_wdata;
            m_active = 1'b1;
            m_p      = 1;
        end
    end

    function automatic logic exp_strobe();
        return m_active && (m_p <= dur());
    endfunction

    function automatic logic exp_ack(input int p);
        return m_active && (m_p == dur() + 1) && (int'(m_port) == p);
    endfunction

    function automatic logic [1:0] exp_gnt();
        return !m_active ? 2'b00 : (m_port ? 2'b10 : 2'b01);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mem_mw",    32'(bus.mem_mw),    32'(exp_strobe() && m_we));
            check("mem_mr",    32'(bus.mem_mr),    32'(exp_strobe() && !m_we));
            check("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
            check("gnt",       32'(bus.gnt),       32'(exp_gnt()));
            check("busy",      32'(bus.busy),      32'(m_active));
            check("m0_ack",    32'(bus.m0_ack),    32'(exp_ack(0)));
            check("m1_ack",    32'(bus.m1_ack),    32'(exp_ack(1)));
            check("m0_rdata",  32'(bus.m0_rdata),  32'(m_rdata0));
            check("m1_rdata",  32'(bus.m1_rdata),  32'(m_rdata1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic drop_req(input int p);
        if (p == 0) bus.m0_req = 1'b0;
        else        bus.m1_req = 1'b0;
    endtask

    function automatic logic req_of(input int p);
        return (p == 0) ? bus.m0_req : bus.m1_req;
    endfunction

    task automatic rand_req(input int p);
        set_req(p, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (bus.busy && c < 50) begin
            tick();
            c++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_ack(input int p, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            seen = (p == 0) ? bus.m0_ack : bus.m1_ack;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (req_of(p)) begin
                    if (exp_ack(p)) begin
                        if ($urandom_range(1) == 1) rand_req(p);
                        else drop_req(p);
                    end else if (m_active && int'(m_port) == p && exp_strobe() && $urandom_range(7) == 0) begin
                        drop_req(p);
                    end
                end else if ($urandom_range(2) == 0) begin
                    rand_req(p);
                end
            end
        end
    endtask

    initial begin
        int n_gnt;
        int who [4];
        int starts [4];
        int exp_seq [4];
        int mr_cycles;
        int ack_at;
        bit saw_mw;
        logic [1:0] prev_gnt;

`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

        tick();
        tick();
        cmp_en = 1'b1;
        check("rst_gnt",      32'(bus.gnt),      32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_strobes",  32'({bus.mem_mw, bus.mem_mr}), 32'd0);
        check("rst_addr",     32'(bus.mem_addr), 32'd0);
        check("rst_rdata",    32'({bus.m0_rdata, bus.m1_rdata}), 32'd0);
        rst = 1'b1;
        tick();

        // Port 0 write 0x10 <- 0xA5.
        set_req(0, 1'b1, 8'h10, 8'hA5);
        tick();
        check("wr_mw",    32'(bus.mem_mw),    32'd1);
        check("wr_mr",    32'(bus.mem_mr),    32'd0);
        check("wr_addr",  32'(bus.mem_addr),  32'h10);
        check("wr_wdata", 32'(bus.mem_wdata), 32'hA5);
        check("wr_gnt",   32'(bus.gnt),       32'b01);
        tick();
        check("wr_ack",   32'(bus.m0_ack),    32'd1);
        check("wr_mw_off", 32'(bus.mem_mw),   32'd0);
        check("wr_gnt_done", 32'(bus.gnt),    32'b01);
        drop_req(0);
        tick();
        check("wr_idle_gnt", 32'(bus.gnt),    32'd0);

        // Port 1 read of 0x10 returns the value just written.
        set_req(1, 1'b0, 8'h10, 8'h00);
        tick();
        for (int k = 1; k <= RD_LAT; k++) begin
            check("rd_mr",  32'(bus.mem_mr), 32'd1);
            check("rd_gnt", 32'(bus.gnt),    32'b10);
            tick();
        end
        check("rd_ack",     32'(bus.m1_ack),   32'd1);
        check("rd_rdata",   32'(bus.m1_rdata), 32'hA5);
        check("rd_mr_off",  32'(bus.mem_mr),   32'd0);
        check("rd_m0_hold", 32'(bus.m0_rdata), 32'd0);
        drop_req(1);
        tick();

        // Both ports request continuously: grant order and one idle cycle between transactions.
        set_req(0, 1'b1, 8'h30, 8'h11);
        set_req(1, 1'b1, 8'h31, 8'h22);
        n_gnt = 0;
        prev_gnt = bus.gnt;
        who = '{-1, -1, -1, -1};
        starts = '{0, 0, 0, 0};
        for (int c = 0; c < 60 && n_gnt < 4; c++) begin
            tick();
            if (prev_gnt == 2'b00 && bus.gnt != 2'b00) begin
                who[n_gnt]    = (bus.gnt == 2'b10) ? 1 : 0;
                starts[n_gnt] = c;
                n_gnt++;
            end
            prev_gnt = bus.gnt;
        end
        drop_req(0);
        drop_req(1);
        check("tie_count", 32'(n_gnt), 32'd4);
        for (int i = 0; i < 4; i++) check("tie_winner", 32'(who[i]), 32'(exp_seq[i]));
        for (int i = 1; i < 4; i++) check("tie_spacing", 32'(starts[i] - starts[i-1]), 32'd3);
        wait_idle("tie_drain");
        tick();

        // Port 0 read with the full latency: count mr cycles, ack position, no write strobe.
        set_req(0, 1'b0, 8'h22, 8'h00);
        mr_cycles = 0;
        ack_at = 0;
        saw_mw = 1'b0;
        for (int c = 1; c <= 20 && ack_at == 0; c++) begin
            tick();
            if (bus.mem_mr) mr_cycles++;
            if (bus.mem_mw) saw_mw = 1'b1;
            if (bus.m0_ack) ack_at = c;
        end
        drop_req(0);
        check("lat_mr_cycles", 32'(mr_cycles),     32'(RD_LAT));
        check("lat_ack_at",    32'(ack_at),        32'(RD_LAT + 1));
        check("lat_no_mw",     32'(saw_mw),        32'd0);
        check("lat_rdata",     32'(bus.m0_rdata),  32'h78);
        tick();

        // Reset during a read access aborts it without waiting for a clock.
        set_req(0, 1'b0, 8'h40, 8'h00);
        tick();
        check("abort_mr_before", 32'(bus.mem_mr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_mr",   32'(bus.mem_mr), 32'd0);
        check("abort_busy", 32'(bus.busy),   32'd0);
        check("abort_gnt",  32'(bus.gnt),    32'd0);
        drop_req(0);
        tick();
        check("abort_no_ack", 32'(bus.m0_ack), 32'd0);
        tick();
        rst = 1'b1;
        set_req(1, 1'b0, 8'h10, 8'h00);
        wait_ack(1, "abort_recover_ack");
        check("abort_recover_rdata", 32'(bus.m1_rdata), 32'hA5);
        drop_req(1);
        tick();

        // Port 1 arrives during port 0's write access and is served at the next idle.
        set_req(0, 1'b1, 8'h50, 8'h66);
        tick();
        set_req(1, 1'b0, 8'h50, 8'h00);
        tick();
        check("late_m0_ack",  32'(bus.m0_ack),  32'd1);
        check("late_strobes", 32'({bus.mem_mw, bus.mem_mr}), 32'd0);
        drop_req(0);
        tick();
        check("late_idle_gnt", 32'(bus.gnt), 32'd0);
        tick();
        check("late_m1_gnt", 32'(bus.gnt),    32'b10);
        check("late_m1_mr",  32'(bus.mem_mr), 32'd1);
        wait_ack(1, "late_m1_ack");
        check("late_m1_rdata", 32'(bus.m1_rdata), 32'h66);
        drop_req(1);
        tick();

        run_random(3000);
        drop_req(0);
        drop_req(1);
        wait_idle("final_drain");
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
